// File: rtl/reg_pkg.sv
// Shared register-file definitions: select codes, default widths, readback FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Used by reg_readback and reg_snapshot_mux; the select codes are also meant for the
// register file's own write-address decode so both sides agree on the encoding.
package reg_pkg;

    // Default register / data width.
    localparam int REG_DATA_W = 8;

    // Default select-code width.
    localparam int REG_SEL_W  = 2;

    // Register select codes.
    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_OUT = 2'b10;
    localparam logic [1:0] SEL_INV = 2'b11;

    // Beat index of the last beat in a burst (A=0, B=1, out=2).
    localparam logic [1:0] LAST_BURST_IDX = 2'd2;

    // Readback FSM states.
    typedef enum logic [1:0] {
        RB_IDLE = 2'd0,
        RB_SEND = 2'd1,
        RB_ERR  = 2'd2
    } rb_state_e;

    // Pick one of three register values by beat index.
    // Index 3 is never produced by the FSM and returns zero.
    function automatic logic [REG_DATA_W-1:0] pick3(
        input logic [1:0]            idx,
        input logic [REG_DATA_W-1:0] va,
        input logic [REG_DATA_W-1:0] vb,
        input logic [REG_DATA_W-1:0] vo
    );
        logic [REG_DATA_W-1:0] r;
        case (idx)
            SEL_A:   r = va;
            SEL_B:   r = vb;
            SEL_OUT: r = vo;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_snapshot_mux.sv
// Snapshot store for registers A, B and out, with beat-index read selection.
// Latency: snapshot loads on the clock edge with load=1; sel_data is combinational.
// Backpressure: none; the owner holds idx steady to keep sel_data stable.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset (snapshot clears to 0)
//   load                  capture in_a/in_b/in_out on the next rising edge
//   in_a, in_b, in_out    live register values from the register file
//   idx                   beat index 0=A, 1=B, 2=out
//   sel_data              value that will be stored at idx after this edge
//
// sel_data shows the post-edge view of the snapshot: when load is asserted it selects
// from the live inputs, otherwise from the stored copy. This lets the owner register the
// very first beat in the same edge that captures the snapshot.
module reg_snapshot_mux
    import reg_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_out,
    input  logic [1:0]        idx,
    output logic [DATA_W-1:0] sel_data
);

    logic [DATA_W-1:0] snap_a;
    logic [DATA_W-1:0] snap_b;
    logic [DATA_W-1:0] snap_out;

    // All three registers load together so a burst returns one coherent view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_a   <= '0;
            snap_b   <= '0;
            snap_out <= '0;
        end else if (load) begin
            snap_a   <= in_a;
            snap_b   <= in_b;
            snap_out <= in_out;
        end
    end

    logic [DATA_W-1:0] view_a;
    logic [DATA_W-1:0] view_b;
    logic [DATA_W-1:0] view_out;

    assign view_a   = load ? in_a   : snap_a;
    assign view_b   = load ? in_b   : snap_b;
    assign view_out = load ? in_out : snap_out;

    always_comb begin
        sel_data = '0;
        case (idx)
            SEL_A:   sel_data = view_a;
            SEL_B:   sel_data = view_b;
            SEL_OUT: sel_data = view_out;
            default: sel_data = '0;
        endcase
    end

endmodule

// File: rtl/reg_readback.sv
// Register readback: returns A, B or out (single) or all three (burst) from a snapshot.
// Latency: rd_valid rises one cycle after the accepting rd_req edge; burst beats back-to-back.
// Backpressure: rd_valid/rd_ready; data, last, err hold while stalled; rd_req ignored when busy.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (aborts any response at once)
//   rd_req              request, sampled only while idle
//   rd_sel              00=A, 01=B, 10=out, 11=invalid (error response); ignored in burst
//   rd_burst            1 = return A, B, out in that order
//   reg_a/reg_b/reg_out live register file outputs (observed only)
//   rd_data, rd_valid   returned beat and its valid
//   rd_ready            consumer accepts the current beat
//   rd_last             final beat of the response
//   rd_err              error response (invalid select), rd_data is 0
//   rd_busy             response in progress, new requests are dropped
//   rd_parity           (READBACK_PARITY_EN only) even parity of rd_data, 0 on error
//
// Optional feature macro: READBACK_PARITY_EN adds the rd_parity output.
module reg_readback
    import reg_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int SEL_W  = REG_SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic              rd_burst,
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [DATA_W-1:0] reg_out,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              rd_err,
    output logic              rd_busy
`ifdef READBACK_PARITY_EN
    ,
    output logic              rd_parity
`endif
);

    localparam logic [SEL_W-1:0] SEL_INV_W = SEL_W'(SEL_INV);

    rb_state_e         state_q;
    rb_state_e         state_d;
    logic [1:0]        idx_q;
    logic [1:0]        idx_d;
    logic              burst_q;
    logic              burst_d;
    logic              snap_load;
    logic              beat_last;
    logic [DATA_W-1:0] snap_sel;
    logic [DATA_W-1:0] rd_data_d;
    logic              rd_last_d;
    logic              rd_err_d;

    // Snapshot store; idx_d is used so the registered beat matches the next state.
    reg_snapshot_mux #(
        .DATA_W (DATA_W)
    ) u_snap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (snap_load),
        .in_a     (reg_a),
        .in_b     (reg_b),
        .in_out   (reg_out),
        .idx      (idx_d),
        .sel_data (snap_sel)
    );

    // A single read is always its own last beat; a burst ends on the out register.
    assign beat_last = !burst_q || (idx_q == LAST_BURST_IDX);

    // Both flags come straight from the state flop, so reset drops them asynchronously.
    assign rd_valid = (state_q != RB_IDLE);
    assign rd_busy  = (state_q != RB_IDLE);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        burst_d   = burst_q;
        snap_load = 1'b0;
        rd_data_d = '0;
        rd_last_d = 1'b0;
        rd_err_d  = 1'b0;

        case (state_q)
            RB_IDLE: begin
                if (rd_req) begin
                    snap_load = 1'b1;
                    burst_d   = rd_burst;
                    if (rd_burst) begin
                        state_d = RB_SEND;
                        idx_d   = SEL_A;
                    end else if (rd_sel == SEL_INV_W) begin
                        state_d = RB_ERR;
                        idx_d   = SEL_A;
                    end else begin
                        state_d = RB_SEND;
                        idx_d   = rd_sel[1:0];
                    end
                end
            end
            RB_SEND: begin
                if (rd_ready) begin
                    if (beat_last) begin
                        state_d = RB_IDLE;
                        idx_d   = SEL_A;
                    end else begin
                        // Never wraps: beat_last stops the burst at index 2.
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            RB_ERR: begin
                if (rd_ready) begin
                    state_d = RB_IDLE;
                end
            end
            default: begin
                state_d = RB_IDLE;
                idx_d   = SEL_A;
            end
        endcase

        // Outputs follow the state being entered, so during a stall the same index is
        // re-selected from the unchanged snapshot and the beat holds.
        case (state_d)
            RB_SEND: begin
                rd_data_d = snap_sel;
                rd_last_d = !burst_d || (idx_d == LAST_BURST_IDX);
            end
            RB_ERR: begin
                rd_last_d = 1'b1;
                rd_err_d  = 1'b1;
            end
            default: begin
                rd_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RB_IDLE;
            idx_q   <= 2'd0;
            burst_q <= 1'b0;
            rd_data <= '0;
            rd_last <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            burst_q <= burst_d;
            rd_data <= rd_data_d;
            rd_last <= rd_last_d;
            rd_err  <= rd_err_d;
        end
    end

`ifdef READBACK_PARITY_EN
    // rd_data_d is zero outside SEND, so parity is zero in ERR and IDLE automatically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_parity <= 1'b0;
        end else begin
            rd_parity <= ^rd_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_reg_readback.sv
// Bench for reg_readback: vector table of single reads, hand-written multi-cycle
// sequences (stall, coherency, busy, reset abort) and a randomized run against a
// queue-based reference model of the expected response beats.
module tb_reg_readback;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd_req;
    logic [SEL_W-1:0]  rd_sel;
    logic              rd_burst;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] reg_out;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;
    logic              rd_err;
    logic              rd_busy;
`ifdef READBACK_PARITY_EN
    logic              rd_parity;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_readback #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_burst (rd_burst),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .reg_out  (reg_out),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_last  (rd_last),
        .rd_err   (rd_err),
        .rd_busy  (rd_busy)
`ifdef READBACK_PARITY_EN
        ,
        .rd_parity (rd_parity)
`endif
    );

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
        logic [1:0] sel;
        logic [7:0] exp_data;
        logic       exp_err;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    // Reference model: the list of beats a request must produce.
    logic [7:0] q_data[$];
    logic       q_last[$];
    logic       q_err[$];

    initial begin
        logic [7:0] ra, rb, ro;
        logic [1:0] rs;
        logic       rbst;
        logic       rdy;
        int         cyc;

        vecs[0] = '{8'h00, 8'h5A, 8'h00, 2'b01, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{8'hC3, 8'h11, 8'h22, 2'b00, 8'hC3, 1'b0, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 8'h07, 2'b10, 8'h07, 1'b0, 1'b1};
        vecs[3] = '{8'hAA, 8'hBB, 8'hCC, 2'b11, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h03, 8'h99, 8'h44, 2'b00, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 8'hFE, 8'h80, 2'b10, 8'h80, 1'b0, 1'b1};

        rst_n    = 1'b0;
        rd_req   = 1'b0;
        rd_sel   = 2'b00;
        rd_burst = 1'b0;
        rd_ready = 1'b0;
        reg_a    = 8'h00;
        reg_b    = 8'h00;
        reg_out  = 8'h00;

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", rd_valid, 1'b0);
        chk("reset_busy",  rd_busy,  1'b0);
        chk("reset_data",  rd_data,  8'h00);
        chk("reset_last",  rd_last,  1'b0);
        chk("reset_err",   rd_err,   1'b0);
`ifdef READBACK_PARITY_EN
        chk("reset_parity", rd_parity, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // ---- Single reads from the vector table ----
        for (int i = 0; i < 6; i++) begin
            reg_a    = vecs[i].a;
            reg_b    = vecs[i].b;
            reg_out  = vecs[i].o;
            rd_sel   = vecs[i].sel;
            rd_burst = 1'b0;
            rd_req   = 1'b1;
            rd_ready = 1'b1;
            tick();
            rd_req = 1'b0;
            chk("single_valid", rd_valid, 1'b1);
            chk("single_data",  rd_data,  vecs[i].exp_data);
            chk("single_last",  rd_last,  1'b1);
            chk("single_err",   rd_err,   vecs[i].exp_err);
            chk("single_busy",  rd_busy,  1'b1);
`ifdef READBACK_PARITY_EN
            chk("single_parity", rd_parity, vecs[i].exp_par);
`endif
            tick();
            chk("single_done_valid", rd_valid, 1'b0);
            chk("single_done_busy",  rd_busy,  1'b0);
            chk("single_done_last",  rd_last,  1'b0);
            chk("single_done_err",   rd_err,   1'b0);
        end

        // ---- Invalid select held stalled, then released ----
        rd_sel = 2'b11; rd_burst = 1'b0; rd_req = 1'b1; rd_ready = 1'b0;
        tick();
        rd_req = 1'b0;
        tick();
        chk("err_stall_valid", rd_valid, 1'b1);
        chk("err_stall_err",   rd_err,   1'b1);
        chk("err_stall_data",  rd_data,  8'h00);
        rd_ready = 1'b1;
        tick();
        chk("err_clear_valid", rd_valid, 1'b0);
        chk("err_clear_err",   rd_err,   1'b0);

        // ---- Burst with 3-cycle stall ----
        reg_a = 8'h11; reg_b = 8'h22; reg_out = 8'h33;
        rd_burst = 1'b1; rd_req = 1'b1; rd_ready = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("burst_first_valid", rd_valid, 1'b1);
        chk("burst_first_data",  rd_data,  8'h11);
        chk("burst_first_last",  rd_last,  1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("burst_stall_data", rd_data, 8'h11);
            chk("burst_stall_last", rd_last, 1'b0);
        end
        rd_ready = 1'b1;
        tick();
        chk("burst_b_data", rd_data, 8'h22);
        chk("burst_b_last", rd_last, 1'b0);
        tick();
        chk("burst_o_data", rd_data, 8'h33);
        chk("burst_o_last", rd_last, 1'b1);
        tick();
        chk("burst_end_valid", rd_valid, 1'b0);
        chk("burst_end_busy",  rd_busy,  1'b0);

        // ---- Coherency: register changes during the burst are not seen ----
        reg_a = 8'h01; reg_b = 8'h42; reg_out = 8'h24;
        rd_burst = 1'b1; rd_req = 1'b1; rd_ready = 1'b1;
        tick();
        rd_req = 1'b0;
        reg_a = 8'hFF; reg_b = 8'hEE; reg_out = 8'hDD;
        chk("coh_a", rd_data, 8'h01);
        tick();
        chk("coh_b", rd_data, 8'h42);
        tick();
        chk("coh_o", rd_data, 8'h24);
        tick();
        chk("coh_end_valid", rd_valid, 1'b0);

        // ---- Request while busy is dropped ----
        reg_a = 8'h0A; reg_b = 8'h0B; reg_out = 8'h0C;
        rd_burst = 1'b1; rd_req = 1'b1; rd_ready = 1'b1;
        tick();
        rd_burst = 1'b0; rd_sel = 2'b00; reg_a = 8'h77;
        chk("busy_a", rd_data, 8'h0A);
        tick();
        chk("busy_b", rd_data, 8'h0B);
        chk("busy_flag", rd_busy, 1'b1);
        tick();
        rd_req = 1'b0;
        chk("busy_o", rd_data, 8'h0C);
        chk("busy_o_last", rd_last, 1'b1);
        tick();
        chk("busy_no_extra1", rd_valid, 1'b0);
        tick();
        chk("busy_no_extra2", rd_valid, 1'b0);

        // ---- Reset mid-burst ----
        reg_a = 8'h5F; reg_b = 8'h6F; reg_out = 8'h7F;
        rd_burst = 1'b1; rd_req = 1'b1; rd_ready = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("abort_pre_valid", rd_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", rd_valid, 1'b0);
        chk("abort_busy",  rd_busy,  1'b0);
        chk("abort_data",  rd_data,  8'h00);
        #1;
        rst_n = 1'b1;
        rd_ready = 1'b1;
        tick();
        chk("abort_after_valid", rd_valid, 1'b0);
        tick();
        chk("abort_after_busy", rd_busy, 1'b0);

        // ---- Randomized requests against the beat-list model ----
        for (int r = 0; r < 150; r++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            ro   = 8'($urandom);
            rs   = 2'($urandom);
            rbst = ($urandom_range(0, 2) == 0);
            reg_a = ra; reg_b = rb; reg_out = ro;
            rd_sel = rs; rd_burst = rbst; rd_req = 1'b1;
            rd_ready = 1'($urandom);
            q_data.delete(); q_last.delete(); q_err.delete();
            if (rbst) begin
                q_data.push_back(ra); q_last.push_back(1'b0); q_err.push_back(1'b0);
                q_data.push_back(rb); q_last.push_back(1'b0); q_err.push_back(1'b0);
                q_data.push_back(ro); q_last.push_back(1'b1); q_err.push_back(1'b0);
            end else if (rs == 2'b11) begin
                q_data.push_back(8'h00); q_last.push_back(1'b1); q_err.push_back(1'b1);
            end else begin
                q_data.push_back(rs == 2'b00 ? ra : (rs == 2'b01 ? rb : ro));
                q_last.push_back(1'b1); q_err.push_back(1'b0);
            end
            tick();
            rd_req = 1'b0;
            cyc = 0;
            while (q_data.size() > 0 && cyc < 40) begin
                chk("rnd_valid", rd_valid, 1'b1);
                chk("rnd_data",  rd_data,  q_data[0]);
                chk("rnd_last",  rd_last,  q_last[0]);
                chk("rnd_err",   rd_err,   q_err[0]);
`ifdef READBACK_PARITY_EN
                chk("rnd_parity", rd_parity, q_err[0] ? 1'b0 : ^q_data[0]);
`endif
                rdy = (cyc > 20) ? 1'b1 : 1'($urandom);
                rd_ready = rdy;
                rd_req   = 1'($urandom);
                rd_sel   = 2'($urandom);
                rd_burst = 1'($urandom);
                reg_a    = 8'($urandom);
                reg_b    = 8'($urandom);
                reg_out  = 8'($urandom);
                tick();
                cyc++;
                if (rdy) begin
                    void'(q_data.pop_front());
                    void'(q_last.pop_front());
                    void'(q_err.pop_front());
                end
            end
            rd_req = 1'b0;
            chk("rnd_beats_left", q_data.size(), 0);
            chk("rnd_idle_valid", rd_valid, 1'b0);
            chk("rnd_idle_busy",  rd_busy,  1'b0);
            if (q_data.size() > 0) begin
                $display("FAIL rnd_timeout: response not drained at request %0d", r);
                errors++;
                break;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_readback.md
Name: reg_readback

Overview:
- Read-side companion to the general-purpose register file. Accepts read requests from the debug/host side and returns register contents through a valid/ready handshake.
- Sources: registers A, B and the output register.
- Two request modes:
  - Single mode returns one selected register.
  - Burst mode returns A, B and out in order, taken from one coherent snapshot.
- Sits beside the register file; observes its outputs only and never writes them.

Parameters:
- DATA_W, 8, width of each register and of rd_data.
- SEL_W, 2, width of the register select code.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_req  input  1  read request; sampled only in IDLE.
- rd_sel  input  SEL_W  select code: 00=A, 01=B, 10=out, 11=invalid. Ignored when rd_burst=1.
- rd_burst  input  1  1 = return all three registers, A then B then out.
- reg_a  input  DATA_W  current value of register A.
- reg_b  input  DATA_W  current value of register B.
- reg_out  input  DATA_W  current value of output register.
- rd_data  output  DATA_W  returned data beat.
- rd_valid  output  1  rd_data is valid.
- rd_ready  input  1  consumer accepts the beat.
- rd_last  output  1  final beat of the response.
- rd_err  output  1  response is an error (invalid select).
- rd_busy  output  1  block is not in IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE.
  - rd_data=0, rd_valid=0, rd_last=0, rd_err=0, rd_busy=0.
  - Snapshot registers = 0; beat index = 0.
- States: IDLE, SEND, ERR.
- IDLE:
  - On a clk edge with rd_req=1, capture reg_a, reg_b and reg_out into snapshot registers simultaneously.
  - Latch the mode.
  - Next state:
    - rd_burst=1 → SEND with index 0.
    - rd_burst=0, rd_sel in {00,01,10} → SEND with index = rd_sel.
    - rd_burst=0, rd_sel=11 → ERR.
- Latency: rd_valid rises exactly one cycle after the request edge.
- SEND:
  - rd_valid=1; rd_data = snapshot[index], registered.
  - rd_last=1 on single mode, or on burst index 2.
  - Beat completes on a cycle with rd_valid & rd_ready.
  - On completion:
    - If last, go to IDLE; rd_valid and rd_last drop the next cycle.
    - Otherwise index+1 and present the next beat in the very next cycle, with no bubble.
- ERR: rd_valid=1, rd_err=1, rd_last=1, rd_data=0. On rd_ready → IDLE.
- Handshake rules:
  - While rd_valid=1 and rd_ready=0, rd_data, rd_last and rd_err hold stable.
  - rd_ready while rd_valid=0 is ignored.
- rd_busy = (state != IDLE).
- rd_req while busy is ignored; it is not queued. The requester must re-issue it after rd_busy falls.
- Register file writes during a response do not affect returned data. The snapshot is taken only at request acceptance.
- Back-to-back requests: the earliest new acceptance is the cycle after return to IDLE. Full burst minimum is 1 + 3 cycles, plus 1 idle cycle.
- Reset mid-response aborts immediately: rd_valid=0 asynchronously and no further beats.
- Index increments only within 0..2; there is no wrap. Index 3 is unreachable.

Optional Feature:
- Macro READBACK_PARITY_EN.
- Defined:
  - Adds output port rd_parity (1 bit) = XOR of rd_data bits (even parity).
  - Registered and aligned with rd_data.
  - 0 at reset and in the ERR response.
- Undefined: the port is absent; all other behaviour is identical.

Decomposition:
- Shared package reg_pkg:
  - Select constants SEL_A=2'b00, SEL_B=2'b01, SEL_OUT=2'b10, SEL_INV=2'b11.
  - DATA_W default.
  - Readback state enum {RB_IDLE, RB_SEND, RB_ERR}.
  - Reusable by the register file's write decode.
- One natural sub-module: reg_snapshot_mux.
  - Holds the three snapshot registers (load enable).
  - Provides combinational beat-index selection.
- The FSM and handshake stay in reg_readback.

Test Plan:
- Single read: reg_b=8'h5A, rd_req=1, rd_sel=01, rd_ready=1 → next cycle rd_valid=1, rd_data=8'h5A, rd_last=1, rd_err=0; following cycle rd_valid=0, rd_busy=0.
- Burst with stall: A=11, B=22, out=33, rd_burst=1; rd_ready held 0 for 3 cycles, then 1 → 11 held stable while stalled, then 22, 33 on consecutive cycles; rd_last only with 33.
- Coherency: burst accepted with A=01; reg_a changes to FF during SEND → beats still 01, B, out as captured.
- Invalid select: rd_sel=11, rd_burst=0 → rd_valid=1, rd_err=1, rd_last=1, rd_data=00; cleared after rd_ready.
- Busy/abort: second rd_req during a burst → ignored, no extra beats. rst_n pulsed low mid-burst → rd_valid=0 immediately; idle after release.
- Parity, with READBACK_PARITY_EN defined: read out=8'h07 → rd_parity=1; read A=8'h03 → rd_parity=0.
